writeback_arbiter: RTL and testbench

- Write-side master for the multi-port register file: collects results from NUM_FU functional units, buffers each in a per-FU FIFO, and each cycle issues up to WB_WIDTH writes onto the register file write ports (addr_rd / rd_data / rd_wen).
- Sits between the execute units and the register file; WB_WIDTH equals the core's DISPATCH_WIDTH.

---
 rtl/writeback_arbiter_if.sv | 27 ++
 rtl/writeback_arbiter.sv | 131 +++++++++++++
 tb/tb_writeback_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// Result-collection and register-file write-port bundle for the writeback arbiter.
// The master modport is the arbiter; the slave side is the functional units plus the register file.
interface writeback_arbiter_if #(
  parameter int NUM_FU         = 4,
  parameter int WB_WIDTH       = 2,
  parameter int NUM_REGS       = 32,
  parameter int REG_WIDTH      = 32,
  parameter int NUM_REGS_WIDTH = $clog2(NUM_REGS)
);
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU-1:0]         fu_ready;
  logic [NUM_REGS_WIDTH-1:0] fu_rd   [NUM_FU];
  logic [REG_WIDTH-1:0]      fu_data [NUM_FU];
  logic [NUM_REGS_WIDTH-1:0] addr_rd [WB_WIDTH];
  logic [REG_WIDTH-1:0]      rd_data [WB_WIDTH];
  logic [WB_WIDTH-1:0]       rd_wen;

  modport master (
    input  fu_valid, fu_rd, fu_data,
    output fu_ready, addr_rd, rd_data, rd_wen
  );

  modport slave (
    output fu_valid, fu_rd, fu_data,
    input  fu_ready, addr_rd, rd_data, rd_wen
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Buffers functional-unit results in per-FU FIFOs and drains up to WB_WIDTH of them per cycle
// onto the register file write ports, round-robin across FUs, with same-register conflicts deferred.
module writeback_arbiter #(
  parameter int NUM_FU         = 4,
  parameter int WB_WIDTH       = 2,
  parameter int NUM_REGS       = 32,
  parameter int REG_WIDTH      = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int NUM_REGS_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  writeback_arbiter_if.master   wb,
  output logic                  idle
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]         empty;
  logic [NUM_FU-1:0]         full;
  logic [NUM_FU-1:0]         push;
  logic [NUM_FU-1:0]         grant;
  logic [NUM_REGS_WIDTH-1:0] head_rd   [NUM_FU];
  logic [REG_WIDTH-1:0]      head_data [NUM_FU];

  logic [FU_W-1:0]           rr_q, rr_d;
  logic [WB_WIDTH-1:0]       port_valid;
  logic [NUM_REGS_WIDTH-1:0] port_rd   [WB_WIDTH];
  logic [REG_WIDTH-1:0]      port_data [WB_WIDTH];
  int                        n_grant;
  logic                      conflict;

  logic [NUM_REGS_WIDTH-1:0] addr_rd_q [WB_WIDTH];
  logic [REG_WIDTH-1:0]      rd_data_q [WB_WIDTH];
  logic [WB_WIDTH-1:0]       rd_wen_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fifo
      logic [NUM_REGS_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
      logic [REG_WIDTH-1:0]      data_mem_q [FIFO_DEPTH];
      logic [PTR_W:0]            wr_ptr_q;
      logic [PTR_W:0]            rd_ptr_q;

      // Extra pointer MSB distinguishes full from empty when the indices match.
      assign empty[gi] = (wr_ptr_q == rd_ptr_q);
      assign full[gi]  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      assign push[gi]         = wb.fu_valid[gi] & ~full[gi];
      assign wb.fu_ready[gi]  = ~full[gi];
      assign head_rd[gi]      = rd_mem_q[rd_ptr_q[PTR_W-1:0]];
      assign head_data[gi]    = data_mem_q[rd_ptr_q[PTR_W-1:0]];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          if (push[gi])  wr_ptr_q <= wr_ptr_q + 1'b1;
          if (grant[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          rd_mem_q[wr_ptr_q[PTR_W-1:0]]   <= wb.fu_rd[gi];
          data_mem_q[wr_ptr_q[PTR_W-1:0]] <= wb.fu_data[gi];
        end
      end
    end
  endgenerate

  // Scan FUs starting at rr; a nonzero rd already granted this cycle defers later heads.
  always_comb begin
    grant      = '0;
    rr_d       = rr_q;
    port_valid = '0;
    n_grant    = 0;
    conflict   = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++) begin
      port_rd[k]   = '0;
      port_data[k] = '0;
    end
    for (int j = 0; j < NUM_FU; j++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (f == ((int'(rr_q) + j) % NUM_FU) && !empty[f] && n_grant < WB_WIDTH) begin
          conflict = 1'b0;
          for (int k = 0; k < WB_WIDTH; k++) begin
            if (k < n_grant && head_rd[f] != '0 && port_rd[k] == head_rd[f]) conflict = 1'b1;
          end
          if (!conflict) begin
            grant[f] = 1'b1;
            for (int k = 0; k < WB_WIDTH; k++) begin
              if (k == n_grant) begin
                port_valid[k] = 1'b1;
                port_rd[k]    = head_rd[f];
                port_data[k]  = head_data[f];
              end
            end
            n_grant = n_grant + 1;
            rr_d    = FU_W'((f + 1) % NUM_FU);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q     <= '0;
      rd_wen_q <= '0;
      for (int k = 0; k < WB_WIDTH; k++) begin
        addr_rd_q[k] <= '0;
        rd_data_q[k] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int k = 0; k < WB_WIDTH; k++) begin
        // x0 results occupy a slot but never raise the write enable.
        rd_wen_q[k]  <= port_valid[k] && (port_rd[k] != '0);
        addr_rd_q[k] <= port_valid[k] ? port_rd[k] : '0;
        if (port_valid[k]) rd_data_q[k] <= port_data[k];
      end
    end
  end

  assign wb.addr_rd = addr_rd_q;
  assign wb.rd_data = rd_data_q;
  assign wb.rd_wen  = rd_wen_q;
  assign idle       = (&empty) & ~(|rd_wen_q);
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, round-robin, conflicts, x0/backpressure, mid-run reset.
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic idle;
  int   total = 0;
  int   bad = 0;

  logic [31:0] rf [32];
  logic [31:0] log9 [$];
  logic [31:0] exp9 [8];

  writeback_arbiter_if #(.NUM_FU(4), .WB_WIDTH(2), .NUM_REGS(32), .REG_WIDTH(32)) wb ();

  writeback_arbiter #(
    .NUM_FU(4), .WB_WIDTH(2), .NUM_REGS(32), .REG_WIDTH(32), .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (wb),
    .idle (idle)
  );

  always #5 clk = ~clk;

  // Register file model: captures enabled write ports at each edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wb.rd_wen[k]) begin
        rf[wb.addr_rd[k]] <= wb.rd_data[k];
        if (wb.addr_rd[k] == 5'd9) log9.push_back(wb.rd_data[k]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] d);
    wb.fu_valid[i] = 1'b1;
    wb.fu_rd[i]    = rd;
    wb.fu_data[i]  = d;
  endtask

  task automatic clear_fu();
    for (int i = 0; i < 4; i++) begin
      wb.fu_valid[i] = 1'b0;
      wb.fu_rd[i]    = '0;
      wb.fu_data[i]  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    exp9[0] = 32'hB0; exp9[1] = 32'hB1; exp9[2] = 32'hC1; exp9[3] = 32'hB2;
    exp9[4] = 32'hA1; exp9[5] = 32'hA2; exp9[6] = 32'hA3; exp9[7] = 32'hA4;
    for (int i = 0; i < 4; i++) set_fu(i, 5'd9, 32'hFF);

    // Reset held two cycles with all FUs valid
    step();
    step();
    check("reset_wen", wb.rd_wen, 2'b00);
    check("reset_idle", idle, 1'b1);
    check("reset_addr0", wb.addr_rd[0], 5'd0);
    rst_n = 1'b1;
    clear_fu();
    check("reset_ready", wb.fu_ready, 4'hF);
    step();
    check("reset_no_push_idle", idle, 1'b1);

    // Single result from FU1: written two edges after the push
    set_fu(1, 5'd5, 32'hDEADBEEF);
    step();
    clear_fu();
    check("single_e0_wen", wb.rd_wen, 2'b00);
    check("single_e0_busy", idle, 1'b0);
    step();
    check("single_wen", wb.rd_wen, 2'b01);
    check("single_addr", wb.addr_rd[0], 5'd5);
    check("single_data", wb.rd_data[0], 32'hDEADBEEF);
    step();
    check("single_after_wen", wb.rd_wen, 2'b00);
    check("single_after_idle", idle, 1'b1);
    check("single_rf5", rf[5], 32'hDEADBEEF);

    // Round-robin over all four FUs from rr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 5'(i + 1), 32'h100 + 32'(i));
    step();
    clear_fu();
    step();
    check("rr_a_wen", wb.rd_wen, 2'b11);
    check("rr_a_addr0", wb.addr_rd[0], 5'd1);
    check("rr_a_addr1", wb.addr_rd[1], 5'd2);
    check("rr_a_data1", wb.rd_data[1], 32'h101);
    step();
    check("rr_b_addr0", wb.addr_rd[0], 5'd3);
    check("rr_b_addr1", wb.addr_rd[1], 5'd4);
    check("rr_b_data0", wb.rd_data[0], 32'h102);
    step();
    check("rr_done_idle", idle, 1'b1);
    // rr must be back at 0: FU0 takes port 0 ahead of FU3
    set_fu(0, 5'd11, 32'h200);
    set_fu(3, 5'd10, 32'h203);
    step();
    clear_fu();
    step();
    check("rr_probe_addr0", wb.addr_rd[0], 5'd11);
    check("rr_probe_addr1", wb.addr_rd[1], 5'd10);
    step();

    // Same-register conflict: FU1 deferred one cycle
    set_fu(0, 5'd7, 32'h11);
    set_fu(1, 5'd7, 32'h22);
    step();
    clear_fu();
    step();
    check("conf_a_wen", wb.rd_wen, 2'b01);
    check("conf_a_addr", wb.addr_rd[0], 5'd7);
    check("conf_a_data", wb.rd_data[0], 32'h11);
    step();
    check("conf_b_wen", wb.rd_wen, 2'b01);
    check("conf_b_data", wb.rd_data[0], 32'h22);
    step();
    check("conf_rf7", rf[7], 32'h22);
    check("conf_idle", idle, 1'b1);

    // x0 entry and backpressure on FU2, starved by rd=9 conflicts
    do_reset();
    log9.delete();
    set_fu(0, 5'd9, 32'hB0); set_fu(1, 5'd12, 32'hC0); set_fu(2, 5'd0, 32'hA0);
    step();
    clear_fu();
    set_fu(0, 5'd9, 32'hB1); set_fu(2, 5'd9, 32'hA1); set_fu(3, 5'd13, 32'hD0);
    step();
    check("bp_e1_wen", wb.rd_wen, 2'b11);
    check("bp_e1_addr1", wb.addr_rd[1], 5'd12);
    clear_fu();
    set_fu(0, 5'd9, 32'hB2); set_fu(2, 5'd9, 32'hA2);
    step();
    check("bp_x0_wen", wb.rd_wen, 2'b10);
    check("bp_x0_addr", wb.addr_rd[0], 5'd0);
    check("bp_x0_data", wb.rd_data[0], 32'hA0);
    check("bp_e2_addr1", wb.addr_rd[1], 5'd13);
    clear_fu();
    set_fu(1, 5'd9, 32'hC1); set_fu(2, 5'd9, 32'hA3); set_fu(3, 5'd14, 32'hD1);
    step();
    check("bp_e3_wen", wb.rd_wen, 2'b01);
    check("bp_e3_data", wb.rd_data[0], 32'hB1);
    clear_fu();
    set_fu(2, 5'd9, 32'hA4);
    step();
    clear_fu();
    check("bp_full_ready", wb.fu_ready, 4'b1011);
    check("bp_e4_data0", wb.rd_data[0], 32'hC1);
    check("bp_e4_data1", wb.rd_data[1], 32'hD1);
    step();
    check("bp_e5_ready", wb.fu_ready, 4'b1011);
    check("bp_e5_data0", wb.rd_data[0], 32'hB2);
    step();
    check("bp_e6_data0", wb.rd_data[0], 32'hA1);
    check("bp_e6_ready", wb.fu_ready, 4'hF);
    begin
      int n = 0;
      while (!idle && n < 20) begin
        step();
        n++;
      end
    end
    check("bp_drain_idle", idle, 1'b1);
    check("bp_log_len", 64'(log9.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_order%0d", i), (i < log9.size()) ? log9[i] : 32'hX, exp9[i]);
    end
    check("bp_rf9", rf[9], 32'hA4);

    // Reset mid-operation with three entries buffered in FU3
    do_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 5'd20, 32'h300 + 32'(i));
    step();
    for (int i = 0; i < 4; i++) set_fu(i, 5'd20, 32'h310 + 32'(i));
    step();
    check("mr_e1_data", wb.rd_data[0], 32'h300);
    clear_fu();
    set_fu(3, 5'd20, 32'h323);
    step();
    check("mr_e2_wen", wb.rd_wen, 2'b01);
    check("mr_e2_data", wb.rd_data[0], 32'h301);
    clear_fu();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_rst_wen", wb.rd_wen, 2'b00);
    check("mr_rst_idle", idle, 1'b1);
    check("mr_rst_ready", wb.fu_ready, 4'hF);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mr_post%0d_wen", c), wb.rd_wen, 2'b00);
      check($sformatf("mr_post%0d_idle", c), idle, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
